// File: rtl/ocl_axil_to_regbus.sv
// AXI4-Lite slave to simple register-bus bridge.
// Carries one transaction at a time. Reads and writes take turns when both
// are offered together. A request that is not acknowledged within TIMEOUT
// cycles is answered with SLVERR.
module ocl_axil_to_regbus #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        s_awvalid,
  input  logic [31:0] s_awaddr,
  output logic        s_awready,
  input  logic        s_wvalid,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_wready,
  output logic        s_bvalid,
  output logic [1:0]  s_bresp,
  input  logic        s_bready,
  input  logic        s_arvalid,
  input  logic [31:0] s_araddr,
  output logic        s_arready,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  input  logic        s_rready,
  output logic        rb_wr_req,
  output logic        rb_rd_req,
  output logic [31:0] rb_addr,
  output logic [31:0] rb_wdata,
  output logic [3:0]  rb_wstrb,
  input  logic        rb_ack,
  input  logic [31:0] rb_rdata
);

  typedef enum logic [2:0] {IDLE, RB_WR, WR_RESP, RB_RD, RD_RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        aw_held, w_held, prio_rd;
  logic [15:0] cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        is_idle, rd_grant, aw_hs, w_hs, timed_out;
  logic        unused_addr_lsbs;

  // Register-bus addresses are word aligned, so the byte offset is dropped.
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  // The ready signals are gated by reset so that they read 0 while reset is held.
  assign is_idle   = (state == IDLE) & rst_main_n;
  assign s_arready = is_idle & ~aw_held & ~w_held & (~s_awvalid | ~s_wvalid | prio_rd);
  assign rd_grant  = s_arvalid & s_arready;
  assign s_awready = is_idle & ~aw_held & ~rd_grant;
  assign s_wready  = is_idle & ~w_held & ~rd_grant;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign timed_out = (cnt == TO_LAST);

  assign rb_wr_req = (state == RB_WR);
  assign rb_rd_req = (state == RB_RD);
  assign rb_addr   = {addr_q, 2'b00};
  assign rb_wdata  = wdata_q;
  assign rb_wstrb  = wstrb_q;
  assign s_bvalid  = (state == WR_RESP);
  assign s_bresp   = bresp_q;
  assign s_rvalid  = (state == RD_RESP);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; an ack takes precedence over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_held & w_held) state_nxt = RB_WR;
        else if (rd_grant)    state_nxt = RB_RD;
      end
      RB_WR:   if (rb_ack | timed_out) state_nxt = WR_RESP;
      WR_RESP: if (s_bready)           state_nxt = IDLE;
      RB_RD:   if (rb_ack | timed_out) state_nxt = RD_RESP;
      RD_RESP: if (s_rready)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured request fields, timeout counter, responses and read/write priority.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      prio_rd <= 1'b0;
      cnt     <= 16'd0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      bresp_q <= 2'b00;
      rdata_q <= 32'd0;
      rresp_q <= 2'b00;
    end else begin
      cnt <= (state == RB_WR || state == RB_RD) ? cnt + 16'd1 : 16'd0;
      case (state)
        IDLE: begin
          if (aw_held & w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
          if (aw_hs) begin
            aw_held <= 1'b1;
            addr_q  <= s_awaddr[31:2];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
          end
          if (rd_grant) addr_q <= s_araddr[31:2];
        end
        RB_WR: begin
          if (rb_ack)         bresp_q <= 2'b00;
          else if (timed_out) bresp_q <= 2'b10;
        end
        WR_RESP: begin
          if (s_bready) begin
            bresp_q <= 2'b00;
            prio_rd <= ~prio_rd;
          end
        end
        RB_RD: begin
          if (rb_ack) begin
            rdata_q <= rb_rdata;
            rresp_q <= 2'b00;
          end else if (timed_out) begin
            rdata_q <= 32'hDEAD_BEEF;
            rresp_q <= 2'b10;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            rdata_q <= 32'd0;
            rresp_q <= 2'b00;
            prio_rd <= ~prio_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ocl_axil_to_regbus.sv
// Directed testbench for ocl_axil_to_regbus: write/read paths, backpressure,
// timeouts, late acks, arbitration order and asynchronous reset.
module tb_ocl_axil_to_regbus;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        rb_wr_req, rb_rd_req, rb_ack;
  logic [31:0] rb_addr, rb_wdata, rb_rdata;
  logic [3:0]  rb_wstrb;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int n;

  ocl_axil_to_regbus #(.TIMEOUT(64)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .rb_wr_req(rb_wr_req), .rb_rd_req(rb_rd_req), .rb_addr(rb_addr),
    .rb_wdata(rb_wdata), .rb_wstrb(rb_wstrb), .rb_ack(rb_ack), .rb_rdata(rb_rdata)
  );

  // 100 MHz main clock.
  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic step();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic finish_write(input string tag, input logic [1:0] exp_resp);
    check_bit({tag, "_bvalid"}, s_bvalid, 1'b1);
    check_word({tag, "_bresp"}, {30'd0, s_bresp}, {30'd0, exp_resp});
    check_bit({tag, "_wr_req_low"}, rb_wr_req, 1'b0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    #1;
    check_bit({tag, "_bvalid_clr"}, s_bvalid, 1'b0);
  endtask

  task automatic finish_read(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    check_bit({tag, "_rvalid"}, s_rvalid, 1'b1);
    check_word({tag, "_rdata"}, s_rdata, exp_data);
    check_word({tag, "_rresp"}, {30'd0, s_rresp}, {30'd0, exp_resp});
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    #1;
    check_bit({tag, "_rvalid_clr"}, s_rvalid, 1'b0);
    check_word({tag, "_rdata_clr"}, s_rdata, 32'd0);
  endtask

  initial begin
    rst_main_n = 1'b0;
    s_awvalid = 1'b0; s_awaddr = 32'd0; s_wvalid = 1'b0; s_wdata = 32'd0;
    s_wstrb = 4'd0; s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = 32'd0;
    s_rready = 1'b0; rb_ack = 1'b0; rb_rdata = 32'd0;

    // Reset state
    repeat (3) step();
    check_bit("rst_awready", s_awready, 1'b0);
    check_bit("rst_arready", s_arready, 1'b0);
    check_bit("rst_wr_req", rb_wr_req, 1'b0);
    check_bit("rst_bvalid", s_bvalid, 1'b0);
    check_bit("rst_rvalid", s_rvalid, 1'b0);
    rst_main_n = 1'b1;
    step();
    check_bit("idle_awready", s_awready, 1'b1);
    check_bit("idle_wready", s_wready, 1'b1);
    check_bit("idle_arready", s_arready, 1'b1);

    // W one cycle ahead of AW, ack two cycles after the request
    s_wvalid = 1'b1; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF;
    #1 check_bit("wfirst_wready", s_wready, 1'b1);
    step();
    s_wvalid = 1'b0; s_awvalid = 1'b1; s_awaddr = 32'h0000_0503;
    #1 check_bit("wfirst_wready_held", s_wready, 1'b0);
    check_bit("wfirst_awready", s_awready, 1'b1);
    step();
    s_awvalid = 1'b0;
    #1 check_bit("wfirst_no_req_yet", rb_wr_req, 1'b0);
    step();
    check_bit("wfirst_wr_req", rb_wr_req, 1'b1);
    check_word("wfirst_addr", rb_addr, 32'h0000_0500);
    check_word("wfirst_wdata", rb_wdata, 32'hA5A5_0001);
    check_word("wfirst_wstrb", {28'd0, rb_wstrb}, 32'h0000_000F);
    step();
    step();
    check_bit("wfirst_wr_req_wait", rb_wr_req, 1'b1);
    check_word("wfirst_addr_stable", rb_addr, 32'h0000_0500);
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_write("wfirst", 2'b00);

    // Read with one-cycle ack and three cycles of R backpressure
    s_arvalid = 1'b1; s_araddr = 32'h0000_0010;
    #1 check_bit("rd_arready", s_arready, 1'b1);
    step();
    s_arvalid = 1'b0;
    #1 check_bit("rd_req", rb_rd_req, 1'b1);
    check_word("rd_addr", rb_addr, 32'h0000_0010);
    rb_rdata = 32'h1234_5678;
    step();
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0; rb_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      check_bit("rd_hold_rvalid", s_rvalid, 1'b1);
      step();
    end
    finish_read("rd", 32'h1234_5678, 2'b00);

    // Read timeout followed by a late ack
    s_arvalid = 1'b1; s_araddr = 32'h0000_0020;
    #1 check_bit("rto_arready", s_arready, 1'b1);
    step();
    s_arvalid = 1'b0;
    n = 0;
    while (rb_rd_req === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check_word("rto_req_cycles", n, 32'd64);
    check_word("rto_rdata", s_rdata, 32'hDEAD_BEEF);
    repeat (4) step();
    rb_ack = 1'b1; rb_rdata = 32'hFFFF_0000;
    step();
    rb_ack = 1'b0;
    #1 check_word("rto_late_ack_rdata", s_rdata, 32'hDEAD_BEEF);
    finish_read("rto", 32'hDEAD_BEEF, 2'b10);

    // Write timeout with no ack
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h0000_0044;
    s_wdata = 32'h0BAD_F00D; s_wstrb = 4'h3;
    #1 check_bit("wto_awready", s_awready, 1'b1);
    check_bit("wto_wready", s_wready, 1'b1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    n = 0;
    while (rb_wr_req === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check_word("wto_req_cycles", n, 32'd64);
    finish_write("wto", 2'b10);

    // Ack arriving in the same cycle as the write timeout
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h0000_0048;
    s_wdata = 32'hCAFE_0048; s_wstrb = 4'h3;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    repeat (63) step();
    check_bit("wlim_wr_req", rb_wr_req, 1'b1);
    check_word("wlim_wstrb", {28'd0, rb_wstrb}, 32'h0000_0003);
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_write("wlim", 2'b00);

    // Asynchronous reset in the middle of a write request
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h0000_0080;
    s_wdata = 32'h0000_0055; s_wstrb = 4'hF;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    check_bit("arst_pre_wr_req", rb_wr_req, 1'b1);
    #1 rst_main_n = 1'b0;
    #1 check_bit("arst_wr_req", rb_wr_req, 1'b0);
    check_bit("arst_bvalid", s_bvalid, 1'b0);
    check_bit("arst_awready", s_awready, 1'b0);
    check_word("arst_addr", rb_addr, 32'd0);
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    step();
    rst_main_n = 1'b1;
    step();
    check_bit("arst_post_bvalid", s_bvalid, 1'b0);
    check_bit("arst_post_awready", s_awready, 1'b1);
    check_bit("arst_post_wr_req", rb_wr_req, 1'b0);

    // Arbitration after reset: write wins first
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_awaddr = 32'h0000_0100; s_wdata = 32'h0000_0011; s_wstrb = 4'hF;
    s_araddr = 32'h0000_0200;
    #1 check_bit("arb1_arready", s_arready, 1'b0);
    check_bit("arb1_awready", s_awready, 1'b1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    check_bit("arb1_wr_req", rb_wr_req, 1'b1);
    check_word("arb1_wr_addr", rb_addr, 32'h0000_0100);
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_write("arb1_wr", 2'b00);
    check_bit("arb1_second_arready", s_arready, 1'b1);
    step();
    s_arvalid = 1'b0;
    #1 check_bit("arb1_rd_req", rb_rd_req, 1'b1);
    check_word("arb1_rd_addr", rb_addr, 32'h0000_0200);
    rb_rdata = 32'h0000_0022; rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_read("arb1_rd", 32'h0000_0022, 2'b00);

    // A lone read flips the priority so the repeat favours the read
    s_arvalid = 1'b1; s_araddr = 32'h0000_0030;
    step();
    s_arvalid = 1'b0;
    rb_rdata = 32'h0000_0033; rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_read("lone_rd", 32'h0000_0033, 2'b00);

    // Arbitration repeat: read wins first
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_awaddr = 32'h0000_0400; s_wdata = 32'h0000_0044; s_wstrb = 4'hF;
    s_araddr = 32'h0000_0300;
    #1 check_bit("arb2_arready", s_arready, 1'b1);
    check_bit("arb2_awready", s_awready, 1'b0);
    check_bit("arb2_wready", s_wready, 1'b0);
    step();
    s_arvalid = 1'b0;
    #1 check_bit("arb2_rd_req", rb_rd_req, 1'b1);
    check_word("arb2_rd_addr", rb_addr, 32'h0000_0300);
    rb_rdata = 32'h0000_0066; rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_read("arb2_rd", 32'h0000_0066, 2'b00);
    check_bit("arb2_second_awready", s_awready, 1'b1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    check_bit("arb2_wr_req", rb_wr_req, 1'b1);
    check_word("arb2_wr_addr", rb_addr, 32'h0000_0400);
    check_word("arb2_wr_data", rb_wdata, 32'h0000_0044);
    rb_ack = 1'b1;
    step();
    rb_ack = 1'b0;
    finish_write("arb2_wr", 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ocl_axil_to_regbus.md
OCL_AXIL_TO_REGBUS -- requirements
Module: ocl_axil_to_regbus

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the register-bus ack timeout in clk_main_a0 cycles (legal range 2..65535).
REQ-002 SHALL have port clk_main_a0  in  1  main clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_main_n  in  1  reset: asynchronous assertion, active-low.
REQ-004 SHALL have AXI4-Lite write address ports: s_awvalid in 1; s_awaddr in 32; s_awready out 1.
REQ-005 SHALL have AXI4-Lite write data ports: s_wvalid in 1; s_wdata in 32; s_wstrb in 4; s_wready out 1.
REQ-006 SHALL have AXI4-Lite write response ports: s_bvalid out 1; s_bresp out 2; s_bready in 1.
REQ-007 SHALL have AXI4-Lite read address ports: s_arvalid in 1; s_araddr in 32; s_arready out 1.
REQ-008 SHALL have AXI4-Lite read data ports: s_rvalid out 1; s_rdata out 32; s_rresp out 2; s_rready in 1.
REQ-009 SHALL have register-bus request ports: rb_wr_req out 1; rb_rd_req out 1; rb_addr out 32 (word address); rb_wdata out 32; rb_wstrb out 4.
REQ-010 SHALL have register-bus completion ports: rb_ack in 1 (single-cycle completion); rb_rdata in 32 (read data, valid with rb_ack).

Function
REQ-011 SHALL implement FSM states IDLE, RB_WR, WR_RESP, RB_RD, RD_RESP, with exactly one transaction in flight.
REQ-012 In IDLE, SHALL capture AW and W independently in either order or in the same cycle. aw_held and w_held flags record each capture. s_awready = IDLE & !aw_held & !rd_grant. s_wready = IDLE & !w_held & !rd_grant.
REQ-013 In IDLE with aw_held and w_held both set (registered), SHALL go to RB_WR on the next edge and clear both flags.
REQ-014 s_arready SHALL equal IDLE & !aw_held & !w_held & (!s_awvalid | !s_wvalid | prio_rd). rd_grant SHALL equal s_arvalid & s_arready.
REQ-015 Arbitration: prio_rd SHALL reset to 0 and toggle after every completed transaction. When a full AW+W pair and AR are offered in the same IDLE cycle, the side selected by prio_rd wins and the other stalls.
REQ-016 On rd_grant, SHALL latch the read address and go to RB_RD.
REQ-017 rb_addr SHALL equal {latched_addr[31:2], 2'b00}. rb_wdata/rb_wstrb SHALL hold the captured W beat. All SHALL be stable while a request is asserted.
REQ-018 rb_wr_req SHALL be high for the whole of RB_WR, and rb_rd_req for the whole of RB_RD. Both SHALL be low in all other states.
REQ-019 A 16-bit timeout counter SHALL clear on entry to RB_WR/RB_RD and increment each cycle in those states.
REQ-020 RB_WR: on rb_ack, SHALL go to WR_RESP with s_bresp=2'b00. If the count reaches TIMEOUT-1 without rb_ack, SHALL go to WR_RESP with s_bresp=2'b10 (SLVERR).
REQ-021 RB_RD: on rb_ack, SHALL register s_rdata=rb_rdata and s_rresp=2'b00, then go to RD_RESP. On timeout, SHALL set s_rdata=32'hDEAD_BEEF and s_rresp=2'b10.
REQ-022 If rb_ack and the timeout coincide in the same cycle, SHALL take the ack (OKAY).
REQ-023 rb_ack SHALL be ignored in every state other than RB_WR/RB_RD; a late ack after a timeout has no effect.
REQ-024 s_bvalid SHALL be high exactly in WR_RESP. s_rvalid SHALL be high exactly in RD_RESP. Response data/resp SHALL be held until the handshake.
REQ-025 On s_bready (in WR_RESP) or s_rready (in RD_RESP), SHALL return to IDLE on the next edge. s_rdata and s_rresp SHALL clear to 0.
REQ-026 Request-to-request latency: minimum 4 cycles per write (capture, RB_WR, WR_RESP, IDLE) with zero-wait ack and ready responder.

Reset
REQ-027 Asserting rst_main_n low SHALL immediately, asynchronously force IDLE and clear aw_held, w_held, prio_rd and the counter. All outputs SHALL go to 0, including mid-transaction; the aborted transaction receives no response.
REQ-028 SHALL resume accepting transactions on the first rising edge after rst_main_n deasserts.

Verification
REQ-029 Write W one cycle before AW (addr 0x0000_0503, data 0xA5A5_0001, strb 0xF), with rb_ack 2 cycles after rb_wr_req -> rb_addr=0x0000_0500, rb_wdata=0xA5A5_0001, s_bresp=0.
REQ-030 Read 0x10 with rb_rdata=0x1234_5678 and ack after 1 cycle; hold s_rready low 3 cycles -> s_rvalid held, s_rdata=0x1234_5678, s_rresp=0.
REQ-031 Read with no rb_ack (TIMEOUT=64) -> rb_rd_req high exactly 64 cycles, s_rdata=0xDEAD_BEEF, s_rresp=2; an ack injected 5 cycles later is ignored.
REQ-032 AW+W and AR offered in the same cycle, twice, after reset -> write served first, read second; order alternates on the repeat.
REQ-033 Assert rst_main_n low during RB_WR -> rb_wr_req, s_bvalid and s_awready drop to 0 without a clock edge; no B response after reset.
REQ-034 rb_ack in the same cycle as the write timeout -> s_bresp=0.
